// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: micro-op word layout,
// ALU op codes and FSM state encoding.
package seq_pkg;

  localparam int INSTR_W  = 10;
  localparam int HALT_BIT = 9;
  localparam int OP_LSB   = 6;
  localparam int OP_W     = 3;
  localparam int DEST_LSB = 4;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_LSB = 0;
  localparam int ADDR_W   = 2;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b011;

  // Field order mirrors instr_data: {halt, alu_op, dest, src1, src2}
  typedef struct packed {
    logic              halt;
    logic [OP_W-1:0]   alu_op;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_instr_fifo.sv
// Synchronous micro-op FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB compare.
module seq_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Issues queued micro-ops to the register/ALU datapath, one per cycle, until
// a HALT word retires. Optional result capture: SEQ_RESULT_CAPTURE_EN.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int DATA_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  srcReg1Addr,
  output logic [ADDR_W-1:0]  srcReg2Addr,
  output logic [ADDR_W-1:0]  destRegAddr,
  output logic [OP_W-1:0]    aluOp,
  output logic               regWrite,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued_count
`ifdef SEQ_RESULT_CAPTURE_EN
  ,
  input  logic [DATA_W-1:0]  aluResult,
  output logic [DATA_W-1:0]  last_result
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_W < 1) begin : g_param_chk
    $error("datapath_sequencer: FIFO_DEPTH must be a power of 2 >= 2, DATA_W >= 1");
  end

  seq_state_e state, state_nxt;
  instr_t     head;
  logic       fifo_full, fifo_empty;
  logic       push, pop, issue;
  logic       rdy_en;

  // Ready is held low until the first edge after reset release
  assign instr_ready = rdy_en & ~fifo_full;
  assign push        = instr_valid & instr_ready;
  assign pop         = (state == ST_RUN) & ~fifo_empty;
  assign issue       = pop & ~head.halt;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

  seq_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (instr_data),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (pop && head.halt) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs hold across bubbles and HALT; only regWrite drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srcReg1Addr  <= '0;
      srcReg2Addr  <= '0;
      destRegAddr  <= '0;
      aluOp        <= '0;
      regWrite     <= 1'b0;
      issued_count <= '0;
    end else begin
      regWrite <= issue;
      if (issue) begin
        srcReg1Addr  <= head.src1;
        srcReg2Addr  <= head.src2;
        destRegAddr  <= head.dest;
        aluOp        <= head.alu_op;
        issued_count <= issued_count + 1'b1;
      end else if (state == ST_IDLE && start) begin
        issued_count <= '0;
      end
    end
  end

`ifdef SEQ_RESULT_CAPTURE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_result <= '0;
    else if (regWrite)
      last_result <= aluResult;
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: queue-level reference model,
// directed scenarios followed by randomized push/start traffic.
module tb_datapath_sequencer;
  import seq_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              instr_valid = 1'b0;
  logic [9:0]        instr_data = '0;
  logic              instr_ready;
  logic [1:0]        srcReg1Addr, srcReg2Addr, destRegAddr;
  logic [2:0]        aluOp;
  logic              regWrite, busy, done;
  logic [CNT_W-1:0]  issued_count;
`ifdef SEQ_RESULT_CAPTURE_EN
  logic [DATA_W-1:0] alu_result, last_result;
  assign alu_result = dp_result(aluOp, srcReg1Addr, srcReg2Addr, destRegAddr);
`endif

  always #5 clk = ~clk;

  datapath_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_ready  (instr_ready),
    .srcReg1Addr  (srcReg1Addr),
    .srcReg2Addr  (srcReg2Addr),
    .destRegAddr  (destRegAddr),
    .aluOp        (aluOp),
    .regWrite     (regWrite),
    .busy         (busy),
    .done         (done),
    .issued_count (issued_count)
`ifdef SEQ_RESULT_CAPTURE_EN
    ,
    .aluResult    (alu_result),
    .last_result  (last_result)
`endif
  );

  // Datapath stand-in: ADD returns A5, other ops a pattern from the operands
  function automatic logic [7:0] dp_result(logic [2:0] op, logic [1:0] s1, logic [1:0] s2, logic [1:0] d);
    return (op == ALU_ADD) ? 8'hA5 : {s1, s2, d, 2'b01};
  endfunction

  function automatic logic [9:0] mk(logic h, logic [2:0] op, logic [1:0] d, logic [1:0] s1, logic [1:0] s2);
    return {h, op, d, s1, s2};
  endfunction

  typedef struct packed {
    logic [1:0] d;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [2:0] op;
  } exp_t;

  // Reference model: word queue plus IDLE(0)/RUN(1)/DONE(2) sequencing
  logic [9:0] m_q[$];
  exp_t       exp_q[$];
  int         m_state = 0;
  int         m_cnt = 0;
  bit         m_rdy_en = 0, m_regwrite = 0, m_pushed = 0, m_rdy = 0;
  logic [1:0] m_d = '0, m_s1 = '0, m_s2 = '0;
  logic [2:0] m_op = '0;
  logic [7:0] m_last = '0;
  logic [9:0] m_w;

  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      exp_q.delete();
      m_state = 0; m_cnt = 0; m_rdy_en = 0; m_regwrite = 0; m_pushed = 0;
      m_d = '0; m_s1 = '0; m_s2 = '0; m_op = '0; m_last = '0;
    end else begin
      if (m_regwrite) m_last = dp_result(m_op, m_s1, m_s2, m_d);
      m_rdy = m_rdy_en && (m_q.size() < DEPTH);
      m_pushed = instr_valid && m_rdy;
      m_regwrite = 0;
      case (m_state)
        0: if (start) begin m_state = 1; m_cnt = 0; end
        1: if (m_q.size() > 0) begin
             m_w = m_q.pop_front();
             if (m_w[9]) m_state = 2;
             else begin
               m_op = m_w[8:6]; m_d = m_w[5:4]; m_s1 = m_w[3:2]; m_s2 = m_w[1:0];
               m_regwrite = 1;
               m_cnt++;
               exp_q.push_back('{d: m_d, s1: m_s1, s2: m_s2, op: m_op});
             end
           end
        default: m_state = 0;
      endcase
      if (m_pushed) m_q.push_back(instr_data);
      m_rdy_en = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every output against the model, pops the scoreboard on regWrite
  exp_t e;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("instr_ready", instr_ready, m_rdy_en && (m_q.size() < DEPTH));
      chk("busy", busy, m_state != 0);
      chk("done", done, m_state == 2);
      chk("regWrite", regWrite, m_regwrite);
      chk("issued_count", issued_count, m_cnt % (1 << CNT_W));
      chk("ctrl_hold", {destRegAddr, srcReg1Addr, srcReg2Addr, aluOp}, {m_d, m_s1, m_s2, m_op});
`ifdef SEQ_RESULT_CAPTURE_EN
      chk("last_result", last_result, m_last);
`endif
      if (regWrite) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_op", {destRegAddr, srcReg1Addr, srcReg2Addr, aluOp}, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_outputs", {srcReg1Addr, srcReg2Addr, destRegAddr, aluOp, regWrite, busy, done}, 0);
    chk("rst_count", issued_count, 0);
    chk("rst_ready", instr_ready, 0);
`ifdef SEQ_RESULT_CAPTURE_EN
    chk("rst_last_result", last_result, 0);
`endif
  endtask

  task automatic push_word(input logic [9:0] w);
    bit ok;
    ok = 0;
    instr_valid = 1'b1;
    instr_data  = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_pushed) begin ok = 1; break; end
    end
    #1;
    instr_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_state == 0) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset();
    repeat (2) step();
    reset_n = 1'b1;
    #1;
    chk("ready_low_before_edge", instr_ready, 0);
    step();
  endtask

  initial begin
    repeat (2) step();
    chk_reset();
    reset_n = 1'b1;
    #1;
    chk("ready_low_before_edge", instr_ready, 0);
    step();

    // Program of four ops then HALT
    push_word(mk(0, ALU_ADD, 2'd0, 2'd1, 2'd2));
    push_word(mk(0, ALU_AND, 2'd1, 2'd2, 2'd3));
    push_word(mk(0, ALU_XOR, 2'd3, 2'd2, 2'd0));
    push_word(mk(0, ALU_SUB, 2'd2, 2'd1, 2'd3));
    pulse_start();
    push_word(mk(1, 3'd0, 2'd0, 2'd0, 2'd0));
    wait_idle();
    step();
    chk("prog_count_wrapped", issued_count, 4 % (1 << CNT_W));
    chk("prog_not_busy", busy, 0);

    // Full FIFO: fifth word waits for a pop
    for (int i = 0; i < 4; i++) push_word(mk(0, ALU_SUB, 2'(i), 2'(i + 1), 2'(i + 2)));
    instr_valid = 1'b1;
    instr_data  = mk(0, ALU_XOR, 2'd3, 2'd3, 2'd1);
    repeat (3) step();
    chk("full_ready_low", instr_ready, 0);
    pulse_start();
    push_word(mk(0, ALU_XOR, 2'd3, 2'd3, 2'd1));
    push_word(mk(1, 3'd0, 2'd0, 2'd0, 2'd0));
    wait_idle();
    step();

    // Starvation: bubbles before the only op
    pulse_start();
    repeat (3) step();
    chk("starve_busy", busy, 1);
    push_word(mk(0, ALU_ADD, 2'd1, 2'd3, 2'd2));
    repeat (3) step();
    chk("starve_still_busy", busy, 1);
    push_word(mk(1, 3'd0, 2'd0, 2'd0, 2'd0));
    wait_idle();
    step();
`ifdef SEQ_RESULT_CAPTURE_EN
    chk("capture_add", last_result, 8'hA5);
`endif

    // start during RUN is ignored; five ops wrap a 2-bit count to 1
    pulse_start();
    push_word(mk(0, ALU_ADD, 2'd0, 2'd0, 2'd1));
    push_word(mk(0, ALU_SUB, 2'd1, 2'd1, 2'd2));
    pulse_start();
    push_word(mk(0, ALU_AND, 2'd2, 2'd2, 2'd3));
    push_word(mk(0, ALU_XOR, 2'd3, 2'd3, 2'd0));
    push_word(mk(0, ALU_ADD, 2'd0, 2'd1, 2'd1));
    push_word(mk(1, 3'd0, 2'd0, 2'd0, 2'd0));
    wait_idle();
    step();
    chk("count_wrap", issued_count, 1);
    chk("sb_drained", exp_q.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_data  = {($urandom_range(0, 5) == 0), 3'($urandom_range(0, 3)), 6'($urandom)};
      start       = ($urandom_range(0, 9) == 0);
      step();
    end
    instr_valid = 1'b0;
    start = 1'b0;

    // Reset mid-run
    do_reset();
    push_word(mk(0, ALU_AND, 2'd3, 2'd1, 2'd0));
    push_word(mk(0, ALU_ADD, 2'd2, 2'd0, 2'd3));
    push_word(mk(0, ALU_SUB, 2'd1, 2'd2, 2'd2));
    pulse_start();
    step();
    do_reset();
    chk("post_reset_ready", instr_ready, 1);
    chk("post_reset_busy", busy, 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
